// File: rtl/gb80_dma.sv
// gb80_dma: Game Boy OAM DMA engine on the shared gb80 external bus.
//
// A CPU write to DMA_REG latches the source page. The engine then copies
// XFER_LEN bytes from {page, 8'h00..} to OAM_BASE.., alternating one READ
// cycle and one WRITE cycle per byte. It owns the bus from the turnaround
// cycle until the last write and holds the CPU off with cpu_mem_disable.
//
// Ports:
//   clock           - system clock, rising edge
//   reset           - synchronous, active-high
//   addr_ext        - shared address bus (driven only while DMA owns bus)
//   data_ext        - shared data bus (driven only in DMA write cycles)
//   mem_we          - CPU write strobe (snooped for the trigger)
//   mem_re          - CPU read strobe (unused; kept for bus symmetry)
//   dma_mem_re      - DMA read strobe to memory
//   dma_mem_we      - DMA write strobe to memory
//   cpu_mem_disable - high while the DMA owns the bus
module gb80_dma #(
    parameter logic [15:0] DMA_REG  = 16'hFF46,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int unsigned XFER_LEN = 160
) (
    input  logic        clock,
    input  logic        reset,
    inout  logic [15:0] addr_ext,
    inout  logic [7:0]  data_ext,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic        dma_mem_re,
    output logic        dma_mem_we,
    output logic        cpu_mem_disable
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      state;
    logic [7:0]  idx;
    logic [7:0]  src_hi;
    logic [7:0]  buf_q;
    logic [15:0] addr_q;
    logic        addr_oe;
    logic        data_oe;

    logic unused_mem_re;
    assign unused_mem_re = mem_re;

    assign addr_ext = addr_oe ? addr_q : 16'hzzzz;
    assign data_ext = data_oe ? buf_q  : 8'hzz;

    // Outputs are registered alongside the state: each branch loads the
    // values that belong to the state being entered, so the outputs are a
    // pure function of the current state and never depend on mem_we.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            src_hi          <= '0;
            buf_q           <= '0;
            addr_q          <= '0;
            addr_oe         <= 1'b0;
            data_oe         <= 1'b0;
            dma_mem_re      <= 1'b0;
            dma_mem_we      <= 1'b0;
            cpu_mem_disable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_we && (addr_ext == DMA_REG)) begin
                        src_hi          <= data_ext;
                        idx             <= '0;
                        state           <= START;
                        cpu_mem_disable <= 1'b1;
                    end
                end

                // Bus turnaround: CPU is held off, nothing driven yet.
                START: begin
                    state      <= READ;
                    addr_q     <= {src_hi, idx};
                    addr_oe    <= 1'b1;
                    dma_mem_re <= 1'b1;
                end

                // Memory answers combinationally; capture it for the write.
                READ: begin
                    buf_q      <= data_ext;
                    state      <= WRITE;
                    addr_q     <= OAM_BASE + {8'h00, idx};
                    data_oe    <= 1'b1;
                    dma_mem_re <= 1'b0;
                    dma_mem_we <= 1'b1;
                end

                WRITE: begin
                    data_oe    <= 1'b0;
                    dma_mem_we <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state           <= IDLE;
                        addr_oe         <= 1'b0;
                        cpu_mem_disable <= 1'b0;
                    end else begin
                        idx        <= idx + 8'd1;
                        state      <= READ;
                        addr_q     <= {src_hi, idx + 8'd1};
                        dma_mem_re <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb80_dma.sv
// tb_gb80_dma: self-checking bench for gb80_dma.
//
// Provides a CPU bus driver and a combinational-read memory on the shared
// bus. The expected per-cycle bus behaviour of a transfer is derived from
// the documented cycle numbering (START at N+1, READ k at N+2+2k, WRITE k
// at N+3+2k, idle from N+322); OAM contents are tracked in a byte array.
// Bus release is checked by having the CPU model drive random values and
// reading them back unchanged.
module tb_gb80_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic        cpu_drv = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    wire  [15:0] addr_ext;
    wire  [7:0]  data_ext;
    logic        dma_mem_re;
    logic        dma_mem_we;
    logic        cpu_mem_disable;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_model [0:159];
    logic [7:0]  img [0:159];

    int tests = 0;
    int fails = 0;

    gb80_dma #(
        .DMA_REG (16'hFF46),
        .OAM_BASE(16'hFE00),
        .XFER_LEN(160)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .addr_ext       (addr_ext),
        .data_ext       (data_ext),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .dma_mem_re     (dma_mem_re),
        .dma_mem_we     (dma_mem_we),
        .cpu_mem_disable(cpu_mem_disable)
    );

    always #5 clock = ~clock;

    assign addr_ext = cpu_drv ? cpu_addr : 16'hzzzz;
    assign data_ext = dma_mem_re ? mem[addr_ext] : (cpu_drv ? cpu_data : 8'hzz);

    always @(posedge clock) begin
        if (mem_we)     mem[addr_ext] <= data_ext;
        if (dma_mem_we) mem[addr_ext] <= data_ext;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is mid-cycle; write is sampled at the next rising edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_drv  = 1'b1;
        mem_we   = 1'b1;
        @(posedge clock);
        #1;
        cpu_drv  = 1'b0;
        mem_we   = 1'b0;
    endtask

    // CPU drives random values; they must come back untouched and the DMA
    // strobes must all be low.
    task automatic probe(input string tag);
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'($urandom);
        d = 8'($urandom);
        cpu_addr = a;
        cpu_data = d;
        cpu_drv  = 1'b1;
        #1;
        chk(tag, {5'b0, cpu_mem_disable, dma_mem_re, dma_mem_we, addr_ext, data_ext},
                 {8'b0, a, d});
        cpu_drv = 1'b0;
    endtask

    task automatic fill_page(input logic [7:0] src);
        for (int k = 0; k < 160; k++) mem[{src, 8'(k)}] = 8'($urandom);
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < 160; i++)
            chk(tag, {24'b0, mem[16'hFE00 + 16'(i)]}, {24'b0, oam_model[i]});
    endtask

    // Triggers a transfer from page src and checks cycles 1..stop_c after
    // the trigger edge. A full run is stop_c = 322.
    task automatic transfer(input logic [7:0] src, input int stop_c);
        int dis_n;
        int re_n;
        int we_n;
        int k;
        logic [31:0] exp;
        dis_n = 0;
        re_n  = 0;
        we_n  = 0;
        // The trigger write itself lands in memory before the copy reads it.
        for (int j = 0; j < 160; j++)
            img[j] = ({src, 8'(j)} == 16'hFF46) ? src : mem[{src, 8'(j)}];
        cpu_write(16'hFF46, src);
        for (int c = 1; c <= stop_c; c++) begin
            @(negedge clock);
            dis_n += int'(cpu_mem_disable);
            re_n  += int'(dma_mem_re);
            we_n  += int'(dma_mem_we);
            if (c == 1) begin
                chk("start", {29'b0, cpu_mem_disable, dma_mem_re, dma_mem_we}, 32'b100);
            end else if (c <= 321) begin
                k = (c - 2) / 2;
                if ((c % 2) == 0)
                    exp = {5'b0, 3'b110, src, 8'(k), img[k]};
                else
                    exp = {5'b0, 3'b101, 16'hFE00 + 16'(k), img[k]};
                chk((c % 2) == 0 ? "read_cyc" : "write_cyc",
                    {5'b0, cpu_mem_disable, dma_mem_re, dma_mem_we, addr_ext, data_ext}, exp);
            end else begin
                probe("release");
            end
        end
        if (stop_c == 322) begin
            chk("disable_cycles", 32'(dis_n), 32'd321);
            chk("read_pulses",    32'(re_n),  32'd160);
            chk("write_pulses",   32'(we_n),  32'd160);
            for (int j = 0; j < 160; j++) oam_model[j] = img[j];
        end
    endtask

    initial begin
        logic [7:0]  s;
        logic [15:0] nt_addr [3];
        logic [7:0]  nt_data;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 160; i++) oam_model[i] = mem[16'hFE00 + 16'(i)];

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        probe("reset_state");
        reset = 1'b0;
        @(negedge clock);
        probe("idle_after_reset");

        // Basic copy with a known pattern
        for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        transfer(8'hC0, 322);
        check_oam("oam_basic");
        for (int i = 0; i < 160; i += 53)
            chk("oam_pattern", {24'b0, mem[16'hFE00 + 16'(i)]}, {24'b0, 8'(i) ^ 8'h5A});

        // Writes near, but not at, the DMA register
        nt_addr[0] = 16'hFF45;
        nt_addr[1] = 16'hFF47;
        nt_addr[2] = 16'hFE00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            nt_data = 8'($urandom);
            cpu_write(nt_addr[i], nt_data);
            if (nt_addr[i] == 16'hFE00) oam_model[0] = nt_data;
            for (int j = 0; j < 4; j++) begin
                @(negedge clock);
                probe("no_trigger");
            end
        end
        check_oam("oam_no_trigger");

        // Reset while reading byte 80
        @(negedge clock);
        s = 8'($urandom_range(0, 8'hFD));
        fill_page(s);
        transfer(s, 162);
        reset = 1'b1;
        @(negedge clock);
        probe("reset_mid");
        reset = 1'b0;
        for (int j = 0; j < 80; j++) oam_model[j] = img[j];
        check_oam("oam_partial");
        s = 8'($urandom_range(0, 8'hFD));
        fill_page(s);
        transfer(s, 322);
        check_oam("oam_after_reset");

        // Highest source page, started back-to-back with the previous copy
        fill_page(8'hFF);
        transfer(8'hFF, 322);
        check_oam("oam_page_ff");

        // Back-to-back random pages
        for (int r = 0; r < 2; r++) begin
            s = 8'($urandom_range(0, 8'hFD));
            fill_page(s);
            transfer(s, 322);
            check_oam("oam_b2b");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
